// File: rtl/isp_lb_pkg.sv
// Shared state type and bank-index helpers for the ISP line buffer controller.
package isp_lb_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StFill   = 2'd1,
        StStream = 2'd2
    } lb_state_e;

    // (base - k) mod n for base, k < n, using a conditional subtract instead of a divider.
    function automatic int unsigned bank_sub(int unsigned base, int unsigned k, int unsigned n);
        int unsigned s;
        s = base + n - k;
        return (s >= n) ? s - n : s;
    endfunction

    function automatic int unsigned bank_inc(int unsigned base, int unsigned n);
        return (base + 1 >= n) ? 32'd0 : base + 1;
    endfunction

endpackage

// File: rtl/lb_row_mux.sv
// Rotates per-bank RAM read data into window rows: row k comes from bank (wr_bank - k) mod MEM_NUM,
// row 0 is the current pixel.
module lb_row_mux
    import isp_lb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 45,
    parameter int unsigned MEM_NUM    = 4,
    parameter int unsigned BANK_W     = 2
) (
    input  logic [BANK_W-1:0]                  wr_bank_i,
    input  logic [DATA_WIDTH-1:0]              row0_i,
    input  logic [MEM_NUM-1:0][DATA_WIDTH-1:0] bank_data_i,
    output logic [MEM_NUM-1:0][DATA_WIDTH-1:0] rows_o
);

    always_comb begin
        rows_o    = '0;
        rows_o[0] = row0_i;
        for (int unsigned k = 1; k < MEM_NUM; k++) begin
            rows_o[k] = bank_data_i[BANK_W'(bank_sub(32'(wr_bank_i), k, MEM_NUM))];
        end
    end

endmodule

// File: rtl/line_buffer_ctrl.sv
// Line buffer controller: writes incoming lines round-robin into MEM_NUM RAM banks and emits a
// vertical pixel window. Define LINE_BUFFER_EDGE_REPLICATE_EN to also output windows during FILL.
module line_buffer_ctrl
    import isp_lb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 11,
    parameter int unsigned DATA_WIDTH = 45,
    parameter int unsigned MEM_NUM    = 4
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic                               frame_start_i,
    input  logic                               line_valid_i,
    input  logic                               pixel_valid_i,
    input  logic [DATA_WIDTH-1:0]              pixel_data_i,
    output logic [MEM_NUM-1:0]                 ram_write_enable_o,
    output logic [MEM_NUM-1:0]                 ram_read_enable_o,
    output logic [ADDR_WIDTH-1:0]              ram_write_address_o,
    output logic [DATA_WIDTH-1:0]              ram_data_o,
    output logic [ADDR_WIDTH-1:0]              ram_read_address_o,
    input  logic [MEM_NUM-1:0][DATA_WIDTH-1:0] ram_data_i,
    output logic                               window_valid_o,
    output logic [MEM_NUM-1:0][DATA_WIDTH-1:0] window_data_o,
    output logic                               overflow_o
);

    localparam int unsigned      BankW    = (MEM_NUM > 1) ? $clog2(MEM_NUM) : 1;
    localparam logic [BankW-1:0] LastBank = BankW'(MEM_NUM - 1);

    lb_state_e state_q, state_d;

    // One extra bit so column 2**ADDR_WIDTH is representable and detects overflow.
    logic [ADDR_WIDTH:0]   col_q, col_d;
    logic [BankW-1:0]      wr_bank_q, wr_bank_d;
    logic [BankW-1:0]      lines_q, lines_d;
    logic                  overflow_q, overflow_d;
    logic                  line_valid_q;

    logic                  line_end;
    logic                  pixel_in;
    logic                  col_full;
    logic                  wr_accept;
    logic                  win_en;
    logic [MEM_NUM-1:0]    wr_onehot;

    logic                  win_valid_q;
    logic [DATA_WIDTH-1:0] pix_q;
    logic [BankW-1:0]      win_bank_q;
    logic [MEM_NUM-1:0][DATA_WIDTH-1:0] rot_rows;
`ifdef LINE_BUFFER_EDGE_REPLICATE_EN
    logic [BankW-1:0]      win_depth_q;
`endif

    assign line_end  = line_valid_q & ~line_valid_i & (state_q != StIdle) & ~frame_start_i;
    assign pixel_in  = line_valid_i & pixel_valid_i & (state_q != StIdle) & ~frame_start_i;
    assign col_full  = col_q[ADDR_WIDTH];
    assign wr_accept = pixel_in & ~col_full;

    // ---------------------------------------------------------------- FSM state register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------------------------------------------------------- FSM next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle, StStream: state_d = state_q;
            StFill: begin
                if (line_end && (lines_d == LastBank)) begin
                    state_d = StStream;
                end
            end
            default: state_d = StIdle;
        endcase
        if (frame_start_i) begin
            state_d = StFill;
        end
    end

    // ---------------------------------------------------------------- FSM outputs
    always_comb begin
        ram_write_enable_o  = '0;
        ram_read_enable_o   = '0;
        ram_write_address_o = '0;
        ram_read_address_o  = '0;
        ram_data_o          = '0;
        win_en              = 1'b0;
        for (int unsigned b = 0; b < MEM_NUM; b++) begin
            wr_onehot[b] = (wr_bank_q == BankW'(b));
        end
        if (wr_accept) begin
            ram_write_enable_o  = wr_onehot;
            ram_read_enable_o   = ~wr_onehot;
            ram_write_address_o = col_q[ADDR_WIDTH-1:0];
            ram_read_address_o  = col_q[ADDR_WIDTH-1:0];
            ram_data_o          = pixel_data_i;
`ifdef LINE_BUFFER_EDGE_REPLICATE_EN
            win_en              = 1'b1;
`else
            win_en              = (state_q == StStream);
`endif
        end
    end

    // ---------------------------------------------------------------- counters
    always_comb begin
        col_d      = col_q;
        wr_bank_d  = wr_bank_q;
        lines_d    = lines_q;
        overflow_d = overflow_q;
        if (frame_start_i) begin
            col_d      = '0;
            wr_bank_d  = '0;
            lines_d    = '0;
            overflow_d = 1'b0;
        end else if (line_end) begin
            col_d     = '0;
            wr_bank_d = BankW'(bank_inc(32'(wr_bank_q), MEM_NUM));
            if (lines_q != LastBank) begin
                lines_d = lines_q + 1'b1;
            end
        end else if (pixel_in) begin
            if (col_full) begin
                overflow_d = 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            col_q        <= '0;
            wr_bank_q    <= '0;
            lines_q      <= '0;
            overflow_q   <= 1'b0;
            line_valid_q <= 1'b0;
        end else begin
            col_q        <= col_d;
            wr_bank_q    <= wr_bank_d;
            lines_q      <= lines_d;
            overflow_q   <= overflow_d;
            line_valid_q <= line_valid_i;
        end
    end

    // ---------------------------------------------------------------- window path
    // Pixel and bank are captured so row 0 lines up with the 1-cycle RAM read latency.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            win_valid_q <= 1'b0;
            pix_q       <= '0;
            win_bank_q  <= '0;
`ifdef LINE_BUFFER_EDGE_REPLICATE_EN
            win_depth_q <= '0;
`endif
        end else begin
            win_valid_q <= win_en;
            if (win_en) begin
                pix_q       <= pixel_data_i;
                win_bank_q  <= wr_bank_q;
`ifdef LINE_BUFFER_EDGE_REPLICATE_EN
                win_depth_q <= lines_q;
`endif
            end
        end
    end

    lb_row_mux #(
        .DATA_WIDTH (DATA_WIDTH),
        .MEM_NUM    (MEM_NUM),
        .BANK_W     (BankW)
    ) u_row_mux (
        .wr_bank_i   (win_bank_q),
        .row0_i      (pix_q),
        .bank_data_i (ram_data_i),
        .rows_o      (rot_rows)
    );

    always_comb begin
        window_data_o = '0;
        if (win_valid_q) begin
            for (int k = 0; k < int'(MEM_NUM); k++) begin
`ifdef LINE_BUFFER_EDGE_REPLICATE_EN
                // Rows older than what has been stored repeat the oldest valid row.
                window_data_o[k] = (k > int'(win_depth_q)) ? rot_rows[win_depth_q] : rot_rows[k];
`else
                window_data_o[k] = rot_rows[k];
`endif
            end
        end
    end

    assign window_valid_o = win_valid_q;
    assign overflow_o     = overflow_q;

endmodule

// File: tb/tb_line_buffer_ctrl.sv
// Randomized bench for line_buffer_ctrl with a bank RAM model, a behavioural reference and a
// window scoreboard. Honours LINE_BUFFER_EDGE_REPLICATE_EN like the design.
module tb_line_buffer_ctrl;

    localparam int AW   = 3;
    localparam int DW   = 8;
    localparam int M    = 4;
    localparam int COLS = 1 << AW;

    localparam int SIdle   = 0;
    localparam int SFill   = 1;
    localparam int SStream = 2;

    typedef logic [M-1:0][DW-1:0] win_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              frame_start;
    logic              line_valid;
    logic              pixel_valid;
    logic [DW-1:0]     pixel_data;
    logic [M-1:0]      ram_we;
    logic [M-1:0]      ram_re;
    logic [AW-1:0]     ram_waddr;
    logic [DW-1:0]     ram_wdata;
    logic [AW-1:0]     ram_raddr;
    win_t              ram_rd;
    logic              win_valid;
    win_t              win_data;
    logic              overflow;

    int checks   = 0;
    int failures = 0;

    // reference model state
    int            m_state, m_col, m_bank, m_lines;
    bit            m_ovf, m_lv_prev;
    logic [DW-1:0] shadow [M][COLS];
    win_t          exp_q[$];

    always #5 clk = ~clk;

    line_buffer_ctrl #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .MEM_NUM    (M)
    ) dut (
        .clk_i               (clk),
        .rst_i               (rst),
        .frame_start_i       (frame_start),
        .line_valid_i        (line_valid),
        .pixel_valid_i       (pixel_valid),
        .pixel_data_i        (pixel_data),
        .ram_write_enable_o  (ram_we),
        .ram_read_enable_o   (ram_re),
        .ram_write_address_o (ram_waddr),
        .ram_data_o          (ram_wdata),
        .ram_read_address_o  (ram_raddr),
        .ram_data_i          (ram_rd),
        .window_valid_o      (win_valid),
        .window_data_o       (win_data),
        .overflow_o          (overflow)
    );

    // Bank RAMs: synchronous read, one cycle latency, contents survive reset.
    initial begin
        logic [DW-1:0] mem [M][COLS];
        for (int b = 0; b < M; b++) for (int c = 0; c < COLS; c++) mem[b][c] = '0;
        ram_rd <= '0;
        forever begin
            @(posedge clk);
            for (int b = 0; b < M; b++) if (ram_re[b]) ram_rd[b] <= mem[b][ram_raddr];
            for (int b = 0; b < M; b++) if (ram_we[b]) mem[b][ram_waddr] = ram_wdata;
        end
    end

    function automatic void check(input string name, input logic [63:0] act,
                                  input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        m_state = SIdle; m_col = 0; m_bank = 0; m_lines = 0; m_ovf = 0; m_lv_prev = 0;
    endfunction

    // Scoreboard monitor: every window must appear exactly one cycle after its pixel.
    initial begin
        win_t w;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (win_valid) begin
                    if (exp_q.size() == 0) begin
                        check("window_unexpected", 64'(win_valid), 64'(0));
                    end else begin
                        w = exp_q.pop_front();
                        check("window_data", 64'(win_data), 64'(w));
                    end
                end else if (exp_q.size() != 0) begin
                    w = exp_q.pop_front();
                    check("window_missing", 64'(win_valid), 64'(1));
                end
            end
        end
    end

    task automatic model_cycle(input logic fs, input logic lv, input logic pv,
                               input logic [DW-1:0] d);
        bit   active, pix, lend, wr, win;
        logic [M-1:0] exp_we, exp_re;
        win_t w;
        int   src;
        active = (m_state != SIdle);
        pix    = lv && pv && active && !fs;
        lend   = m_lv_prev && !lv && active && !fs;
        wr     = pix && (m_col < COLS);
        exp_we = '0;
        exp_re = '0;
        if (wr) begin
            exp_we[m_bank] = 1'b1;
            exp_re = ~exp_we;
        end
        check("ram_write_enable", 64'(ram_we), 64'(exp_we));
        check("ram_read_enable", 64'(ram_re), 64'(exp_re));
        check("overflow", 64'(overflow), 64'(m_ovf));
        if (wr) begin
            check("ram_write_address", 64'(ram_waddr), 64'(m_col));
            check("ram_read_address", 64'(ram_raddr), 64'(m_col));
            check("ram_write_data", 64'(ram_wdata), 64'(d));
        end
`ifdef LINE_BUFFER_EDGE_REPLICATE_EN
        win = wr;
`else
        win = wr && (m_state == SStream);
`endif
        if (win) begin
            for (int k = 0; k < M; k++) begin
                src  = (k > m_lines) ? m_lines : k;
                w[k] = (src == 0) ? d : shadow[(m_bank - src + M) % M][m_col];
            end
            exp_q.push_back(w);
        end
        if (wr) shadow[m_bank][m_col] = d;

        m_lv_prev = lv;
        if (fs) begin
            m_state = SFill; m_col = 0; m_bank = 0; m_lines = 0; m_ovf = 0;
        end else if (lend) begin
            m_col  = 0;
            m_bank = (m_bank + 1) % M;
            if (m_lines < M - 1) m_lines++;
            if (m_state == SFill && m_lines == M - 1) m_state = SStream;
        end else if (pix) begin
            if (m_col == COLS) m_ovf = 1;
            else m_col++;
        end
    endtask

    task automatic step(input logic fs, input logic lv, input logic pv, input logic [DW-1:0] d);
        @(negedge clk);
        frame_start = fs; line_valid = lv; pixel_valid = pv; pixel_data = d;
        #4;
        model_cycle(fs, lv, pv, d);
    endtask

    // fs_at >= 0 places a frame start on that column (its pixel is dropped).
    task automatic send_line(input int line, input int npix, input bit rnd, input int gap_pct,
                             input int fs_at);
        logic [DW-1:0] d;
        for (int c = 0; c < npix; c++) begin
            if (gap_pct > 0 && $urandom_range(99) < gap_pct) step(0, 1, 0, 8'($urandom));
            d = rnd ? 8'($urandom) : 8'(line * 16 + c);
            step((c == fs_at) ? 1'b1 : 1'b0, 1, 1, d);
        end
        repeat ($urandom_range(1, 3)) step(0, 0, 0, 8'($urandom));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_write_enable"}, 64'(ram_we), 64'(0));
        check({tag, "_read_enable"}, 64'(ram_re), 64'(0));
        check({tag, "_write_address"}, 64'(ram_waddr), 64'(0));
        check({tag, "_read_address"}, 64'(ram_raddr), 64'(0));
        check({tag, "_write_data"}, 64'(ram_wdata), 64'(0));
        check({tag, "_window_valid"}, 64'(win_valid), 64'(0));
        check({tag, "_window_data"}, 64'(win_data), 64'(0));
        check({tag, "_overflow"}, 64'(overflow), 64'(0));
    endtask

    initial begin
        rst = 1; frame_start = 0; line_valid = 0; pixel_valid = 0; pixel_data = '0;
        for (int b = 0; b < M; b++) for (int c = 0; c < COLS; c++) shadow[b][c] = '0;
        model_reset();
        repeat (2) @(negedge clk);
        #1 check_all_zero("reset");
        @(negedge clk);
        rst = 0;

        // Pixels before any frame start must not touch the RAMs.
        send_line(9, 8, 1, 20, -1);

        // Directed frame: 6 full lines, pixel = line*16+col.
        step(1, 0, 0, '0);
        for (int l = 0; l < 6; l++) send_line(l, 8, 0, 0, -1);
        // Over-long line, then overflow must persist until the next frame start.
        send_line(6, 9, 0, 0, -1);
        send_line(7, 8, 0, 0, -1);

        // Frame start in the middle of line 4.
        step(1, 0, 0, '0);
        for (int l = 0; l < 4; l++) send_line(l, 8, 0, 0, -1);
        send_line(4, 8, 0, 0, 3);
        for (int l = 5; l < 9; l++) send_line(l, 8, 0, 0, -1);

        // Randomized frames: ragged lines, gaps, occasional mid-line frame start.
        for (int f = 0; f < 6; f++) begin
            step(1, 0, 0, '0);
            for (int l = 0; l < int'($urandom_range(2, 8)); l++) begin
                send_line(l, $urandom_range(1, 9), 1, 25,
                          ($urandom_range(9) == 0) ? int'($urandom_range(0, 7)) : -1);
            end
        end

        // Reset in the middle of line 2.
        step(1, 0, 0, '0);
        send_line(0, 8, 0, 0, -1);
        send_line(1, 8, 0, 0, -1);
        for (int c = 0; c < 4; c++) step(0, 1, 1, 8'(2 * 16 + c));
        @(negedge clk);
        #2 rst = 1;
        #1 check_all_zero("mid_reset");
        exp_q.delete();
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 0;
        m_lv_prev = 1;
        for (int c = 4; c < 8; c++) step(0, 1, 1, 8'(2 * 16 + c));
        repeat (2) step(0, 0, 0, '0);
        send_line(3, 8, 0, 0, -1);
        step(1, 0, 0, '0);
        for (int l = 0; l < 5; l++) send_line(l, 8, 0, 0, -1);

        repeat (3) step(0, 0, 0, '0);
        check("scoreboard_drained", 64'(exp_q.size()), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
